// File: rtl/mult_div_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mult_div_ctrl_pkg : shared op codes, FSM states and helpers for the MD unit
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package mult_div_ctrl_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult_div_ctrl_calc.sv
// ---------------------------------------------------------------------------
// md_calc : combinational 64-bit {hi,lo} result for mult/multu/div/divu
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module md_calc
  import mult_div_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0]   i_a,
  input  logic [DATA_W-1:0]   i_b,
  input  logic [2:0]          i_op,
  output logic [2*DATA_W-1:0] o_result,
  output logic                o_keep
);

  logic [2*DATA_W-1:0] w_sprod;
  logic [2*DATA_W-1:0] w_uprod;
  logic                w_signed_div;
  logic [DATA_W-1:0]   w_a_mag;
  logic [DATA_W-1:0]   w_b_mag;
  logic [DATA_W-1:0]   w_num;
  logic [DATA_W-1:0]   w_den;
  logic [DATA_W-1:0]   w_den_safe;
  logic [DATA_W-1:0]   w_q;
  logic [DATA_W-1:0]   w_r;
  logic [DATA_W-1:0]   w_q_fix;
  logic [DATA_W-1:0]   w_r_fix;

  assign w_sprod = $signed({{DATA_W{i_a[DATA_W-1]}}, i_a}) *
                   $signed({{DATA_W{i_b[DATA_W-1]}}, i_b});
  assign w_uprod = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};

  // Signed divide runs on magnitudes; 0x80000000 stays 0x80000000 as an
  // unsigned magnitude, which makes the overflow case fall out naturally.
  assign w_signed_div = (i_op == MD_DIV);
  assign w_a_mag      = i_a[DATA_W-1] ? (~i_a + 1'b1) : i_a;
  assign w_b_mag      = i_b[DATA_W-1] ? (~i_b + 1'b1) : i_b;
  assign w_num        = w_signed_div ? w_a_mag : i_a;
  assign w_den        = w_signed_div ? w_b_mag : i_b;
  assign w_den_safe   = (w_den == '0) ? {{(DATA_W-1){1'b0}}, 1'b1} : w_den;
  assign w_q          = w_num / w_den_safe;
  assign w_r          = w_num % w_den_safe;
  assign w_q_fix      = (i_a[DATA_W-1] ^ i_b[DATA_W-1]) ? (~w_q + 1'b1) : w_q;
  assign w_r_fix      = i_a[DATA_W-1] ? (~w_r + 1'b1) : w_r;

  always_comb begin
    o_result = '0;
    o_keep   = 1'b0;
    case (md_op_e'(i_op))
      MD_MULT:  o_result = w_sprod;
      MD_MULTU: o_result = w_uprod;
      MD_DIV: begin
        o_keep   = (i_b == '0);
        o_result = {w_r_fix, w_q_fix};
      end
      MD_DIVU: begin
        o_keep   = (i_b == '0);
        o_result = {w_r, w_q};
      end
      default: o_keep = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mult_div_ctrl.sv
// ---------------------------------------------------------------------------
// mult_div_ctrl : multi-cycle mult/div controller owning HI/LO and Busy
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mult_div_ctrl
  import mult_div_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  input  logic [2:0]        MDOp,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              Busy,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO
);

  localparam int CNT_W = $clog2(max_i(MULT_CYCLES, DIV_CYCLES) + 1);

  md_state_e           r_state;
  md_state_e           w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic [DATA_W-1:0]   w_hi_nxt;
  logic [DATA_W-1:0]   w_lo_nxt;
  logic [DATA_W-1:0]   r_tmp_hi;
  logic [DATA_W-1:0]   r_tmp_lo;
  logic [2*DATA_W-1:0] w_tmp_nxt;
  logic [2*DATA_W-1:0] w_calc;
  logic                w_keep;
  logic [2*DATA_W-1:0] w_latch;

  md_calc u_calc (
    .i_a      (A),
    .i_b      (B),
    .i_op     (MDOp),
    .o_result (w_calc),
    .o_keep   (w_keep)
  );

  // A kept result reloads the current HI/LO so completion is a no-op write.
  assign w_latch = w_keep ? {r_hi, r_lo} : w_calc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_tmp_hi <= '0;
      r_tmp_lo <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
      r_tmp_hi <= w_tmp_nxt[2*DATA_W-1:DATA_W];
      r_tmp_lo <= w_tmp_nxt[DATA_W-1:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_tmp_nxt   = {r_tmp_hi, r_tmp_lo};
    case (r_state)
      ST_IDLE: begin
        if (Start) begin
          case (md_op_e'(MDOp))
            MD_MULT, MD_MULTU: begin
              w_state_nxt = ST_BUSY;
              w_cnt_nxt   = CNT_W'(MULT_CYCLES);
              w_tmp_nxt   = w_latch;
            end
            MD_DIV, MD_DIVU: begin
              w_state_nxt = ST_BUSY;
              w_cnt_nxt   = CNT_W'(DIV_CYCLES);
              w_tmp_nxt   = w_latch;
            end
            MD_MTHI: w_hi_nxt = A;
            MD_MTLO: w_lo_nxt = A;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        // Commands arriving here are dropped; the hazard unit should prevent them.
        if (r_cnt > CNT_W'(1)) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_state_nxt = ST_IDLE;
          w_hi_nxt    = r_tmp_hi;
          w_lo_nxt    = r_tmp_lo;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign Busy = (r_state == ST_BUSY);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mult_div_ctrl : vector table, corner sequences and random run vs model
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mult_div_ctrl;
  import mult_div_ctrl_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks = 0;
  int n_err    = 0;

  mult_div_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .MDOp  (MDOp),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: arithmetic from the op definitions, timing as "cycles left".
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] hi,
                                         input logic [31:0] lo);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    logic [31:0] uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MD_MULT:  return sa * sb;
      MD_MULTU: return ua * ub;
      MD_DIV: begin
        if (b == 0) return {hi, lo};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      MD_DIVU: begin
        if (b == 0) return {hi, lo};
        uq = a / b;
        ur = a % b;
        return {ur, uq};
      end
      default: return {hi, lo};
    endcase
  endfunction

  int          m_busy;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_pend <= '0;
    end else if (m_busy > 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) begin
        m_hi <= m_pend[63:32];
        m_lo <= m_pend[31:0];
      end
    end else if (Start) begin
      case (MDOp)
        MD_MULT, MD_MULTU: begin
          m_busy <= MULT_N;
          m_pend <= ref_md(MDOp, A, B, m_hi, m_lo);
        end
        MD_DIV, MD_DIVU: begin
          m_busy <= DIV_N;
          m_pend <= ref_md(MDOp, A, B, m_hi, m_lo);
        end
        MD_MTHI: m_hi <= A;
        MD_MTLO: m_lo <= A;
        default: ;
      endcase
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int cyc, input logic [31:0] hi,
                        input logic [31:0] lo);
    int n;
    Start = 1'b1;
    MDOp  = op;
    A     = a;
    B     = b;
    tick();
    Start = 1'b0;
    MDOp  = MD_NONE;
    n = 0;
    while (Busy === 1'b1 && n < 64) begin
      n++;
      tick();
    end
    chk({name, "_cycles"}, 32'(n), 32'(cyc));
    chk({name, "_hi"}, HI, hi);
    chk({name, "_lo"}, LO, lo);
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n;
    vecs[0] = '{"mult_neg",   MD_MULT,  32'hFFFFFFFD, 32'd5,        MULT_N, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1] = '{"multu_max",  MD_MULTU, 32'hFFFFFFFF, 32'd2,        MULT_N, 32'h00000001, 32'hFFFFFFFE};
    vecs[2] = '{"div_neg",    MD_DIV,   32'hFFFFFFF9, 32'd2,        DIV_N,  32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{"divu_7_2",   MD_DIVU,  32'd7,        32'd2,        DIV_N,  32'h00000001, 32'h00000003};
    vecs[4] = '{"mthi",       MD_MTHI,  32'h00001234, 32'd0,        0,      32'h00001234, 32'h00000003};
    vecs[5] = '{"mtlo",       MD_MTLO,  32'h00005678, 32'd0,        0,      32'h00001234, 32'h00005678};
    vecs[6] = '{"divu_by0",   MD_DIVU,  32'd7,        32'd0,        DIV_N,  32'h00001234, 32'h00005678};
    vecs[7] = '{"div_ovf",    MD_DIV,   32'h80000000, 32'hFFFFFFFF, DIV_N,  32'h00000000, 32'h80000000};

    reset = 1'b0;
    Start = 1'b0;
    MDOp  = MD_NONE;
    A     = '0;
    B     = '0;
    #2 reset = 1'b1;
    #2;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    #14 reset = 1'b0;
    tick();
    chk("idle_busy", 32'(Busy), 32'd0);

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cyc, vecs[i].hi, vecs[i].lo);

    // Commands issued mid-mult must be dropped.
    Start = 1'b1; MDOp = MD_MULT; A = 32'd7; B = 32'd6;
    tick();
    Start = 1'b0;
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      if (Busy === 1'b1) n++;
      Start = 1'b0;
      MDOp  = MD_NONE;
      if (k == 2) begin Start = 1'b1; MDOp = MD_MTLO; A = 32'hDEAD; end
      if (k == 3) begin Start = 1'b1; MDOp = MD_DIV;  A = 32'd100; B = 32'd3; end
      tick();
    end
    chk("ignore_cycles", 32'(n), 32'(MULT_N));
    chk("ignore_hi", HI, 32'd0);
    chk("ignore_lo", LO, 32'd42);
    chk("ignore_busy", 32'(Busy), 32'd0);

    // Asynchronous reset in the middle of a divide.
    run_op("mthi_pre", MD_MTHI, 32'hBEEF, 32'd0, 0, 32'hBEEF, 32'd42);
    Start = 1'b1; MDOp = MD_DIV; A = 32'd100; B = 32'd7;
    tick();
    Start = 1'b0; MDOp = MD_NONE;
    tick();
    tick();
    chk("pre_rst_busy", 32'(Busy), 32'd1);
    #3 reset = 1'b1;
    #1;
    chk("async_busy", 32'(Busy), 32'd0);
    chk("async_hi", HI, 32'd0);
    chk("async_lo", LO, 32'd0);
    #2 reset = 1'b0;
    for (int k = 0; k < DIV_N + 2; k++) tick();
    chk("post_rst_hi", HI, 32'd0);
    chk("post_rst_lo", LO, 32'd0);
    run_op("mult_after_rst", MD_MULT, 32'hFFFFFFFD, 32'd5, MULT_N, 32'hFFFFFFFF, 32'hFFFFFFF1);

    // Random traffic, every cycle compared with the model.
    for (int i = 0; i < 3000; i++) begin
      chk("rnd_busy", 32'(Busy), 32'(m_busy > 0));
      chk("rnd_hi", HI, m_hi);
      chk("rnd_lo", LO, m_lo);
      Start = ($urandom_range(0, 2) == 0);
      MDOp  = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       A = 32'h80000000;
        1:       A = 32'hFFFFFFFF;
        default: A = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       B = 32'd0;
        1:       B = 32'hFFFFFFFF;
        2:       B = 32'($urandom_range(1, 9));
        default: B = $urandom;
      endcase
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mult_div_ctrl.md
Name: mult_div_ctrl

Overview:
- Multi-cycle multiply/divide controller with architectural HI/LO registers.
- Sits in the EX stage beside the ALU; executes mult/multu/div/divu/mthi/mtlo.
- Asserts Busy so the hazard unit stalls mfhi/mflo and later MD instructions while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, number of cycles Busy stays high for mult/multu (must be ≥ 1).
- DIV_CYCLES, 10, number of cycles Busy stays high for div/divu (must be ≥ 1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- Start  input  1  qualifies MDOp for the current cycle; one-cycle pulse from EX.
- MDOp  input  3  op select: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
- A  input  32  rs operand; dividend, multiplicand, or mthi/mtlo source.
- B  input  32  rt operand; divisor or multiplier.
- Busy  output  1  high while a mult/div is in flight (registered).
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.

Behaviour:
- Reset (async, any time): state←IDLE, cnt←0, HI←0, LO←0, Busy←0, and result temporaries←0. An in-flight result is discarded; no HI/LO write follows the reset.
- FSM has two states, IDLE and BUSY. Busy = (state==BUSY); it has no combinational path from Start.
- Accepted arithmetic op: Start=1, state IDLE, and MDOp∈{1,2,3,4}. At that edge:
  - state←BUSY.
  - cnt←MULT_CYCLES for mult/multu, DIV_CYCLES for div/divu.
  - The full 64-bit result is computed combinationally from A/B and latched into tmp_hi/tmp_lo.
- BUSY, each edge:
  - If cnt>1: cnt←cnt−1.
  - If cnt==1: state←IDLE, HI←tmp_hi, LO←tmp_lo.
- Net timing: Busy is high for exactly N cycles after the Start cycle. New HI/LO are visible in the first cycle Busy is low again.
- mult: signed 32×32→64; HI=product[63:32], LO=product[31:0].
- multu: the same, with unsigned operands.
- div (signed):
  - LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: LO = unsigned quotient, HI = unsigned remainder.
- Divide by zero (B==0, div or divu):
  - Timing is unchanged: Busy is high for DIV_CYCLES.
  - At completion, HI and LO retain their prior values (tmp loaded with current HI/LO).
- mthi/mtlo: Start=1 and state IDLE. HI←A (or LO←A) at that edge; Busy stays 0; no latency.
- Start while BUSY: ignored for every MDOp. The hazard unit guarantees this does not occur; the RTL must still ignore it.
- MDOp 0 or 7 with Start=1: no effect.
- Start=0: MDOp, A and B are don't-care.
- Counter width is $clog2(max(MULT_CYCLES, DIV_CYCLES)+1).

Decomposition:
- The MDOp encodings (MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO) go in the shared macrodefine.v alongside the ALU op codes. The controller and the control decoder both use them.
- One sub-module: md_calc, purely combinational. It takes A, B and MDOp and produces the 64-bit {hi,lo} result, including the divide-by-zero and overflow rules, with "keep" indicated by a flag.
- mult_div_ctrl owns the FSM, counter, temporaries and HI/LO.

Test Plan:
- Reset then idle: HI=LO=0, Busy=0. Start=1, MDOp=mult, A=0xFFFFFFFD (−3), B=5. Required: Busy high for exactly 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFF1.
- multu, A=0xFFFFFFFF, B=2. Required: after 5 Busy cycles, HI=0x00000001 and LO=0xFFFFFFFE.
- div, A=0xFFFFFFF9 (−7), B=2. Required: Busy for 10 cycles, then LO=0xFFFFFFFD and HI=0xFFFFFFFF. divu with A=7, B=2 gives LO=3, HI=1.
- Preload HI=0x1234 (mthi) and LO=0x5678 (mtlo), each with Busy=0 and taking effect next cycle. Then divu with A=7, B=0. Required: Busy for 10 cycles and HI/LO stay 0x1234/0x5678. div 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.
- During a mult, on cycle 2 of Busy, pulse Start with mtlo A=0xDEAD and then with div. Required: both are ignored, Busy still ends after 5 cycles, and LO holds the mult result.
- Assert reset asynchronously (mid-clock) at Busy cycle 3 of a div. Required: Busy=0 and HI=LO=0 immediately. After release, a fresh mult completes normally.
